// File: rtl/reorder_buffer_pkg.sv
// Shared sizing for the reorder buffer and the execute stage that feeds it.
// The global size macros get fallback values here so this slice also builds on its own.
`ifndef ROB_ID_SIZE
`define ROB_ID_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DEST_ADDR_SIZE
`define DEST_ADDR_SIZE 5
`endif
`ifndef ROB_CTRL_WIDTH
`define ROB_CTRL_WIDTH 6
`endif

package reorder_buffer_pkg;
    localparam int ROB_ID_SIZE_DEFAULT   = `ROB_ID_SIZE;
    localparam int DATA_WIDTH_DEFAULT    = `DATA_WIDTH;
    localparam int DEST_REG_SIZE_DEFAULT = `DEST_ADDR_SIZE;
    localparam int CTRL_WIDTH_DEFAULT    = `ROB_CTRL_WIDTH;
endpackage

// File: rtl/reorder_buffer_ptr.sv
// Wrap-bit pointer: the low bits index the buffer, and the MSB toggles on each lap.
module rob_ptr #(
    parameter int ID_SIZE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    output logic [ID_SIZE:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at the tail, execute marks entries done
// by id, and the head entry retires one per cycle once it is done.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ID_SIZE   = ROB_ID_SIZE_DEFAULT,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int DEST_REG_SIZE = DEST_REG_SIZE_DEFAULT,
    parameter int CTRL_WIDTH    = CTRL_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alloc_valid,
    input  logic [DEST_REG_SIZE-1:0] alloc_dest_reg,
    input  logic                     alloc_is_store,
    output logic [ROB_ID_SIZE-1:0]   alloc_rob_entry,
    output logic                     rob_full,
    output logic                     rob_empty,
    output logic [ROB_ID_SIZE:0]     rob_count,
    input  logic                     wb_valid,
    input  logic [ROB_ID_SIZE-1:0]   wb_rob_entry,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic [CTRL_WIDTH-1:0]    wb_ctrl,
    output logic                     commit_valid,
    output logic [ROB_ID_SIZE-1:0]   commit_rob_entry,
    output logic [DEST_REG_SIZE-1:0] commit_dest_reg,
    output logic [DATA_WIDTH-1:0]    commit_data,
    output logic [CTRL_WIDTH-1:0]    commit_ctrl,
    output logic                     commit_store,
    output logic                     wb_err
);

    localparam int DEPTH = 1 << ROB_ID_SIZE;

    logic [ROB_ID_SIZE:0]   head_ptr;
    logic [ROB_ID_SIZE:0]   tail_ptr;
    logic [ROB_ID_SIZE-1:0] head_idx;
    logic [ROB_ID_SIZE-1:0] tail_idx;

    logic [DEPTH-1:0]         valid_reg;
    logic [DEPTH-1:0]         done_reg;
    logic [DEPTH-1:0]         store_reg;
    logic [DEST_REG_SIZE-1:0] dest_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0]    ctrl_mem [DEPTH];

    logic alloc_fire;
    logic wb_ok;
    logic wb_fire;
    logic wb_bad;
    logic commit_fire;

    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] wb_sel;
    logic [DEPTH-1:0] commit_sel;

    assign head_idx = head_ptr[ROB_ID_SIZE-1:0];
    assign tail_idx = tail_ptr[ROB_ID_SIZE-1:0];

    assign rob_empty       = (head_ptr == tail_ptr);
    assign rob_full        = (head_idx == tail_idx) &&
                             (head_ptr[ROB_ID_SIZE] != tail_ptr[ROB_ID_SIZE]);
    assign rob_count       = tail_ptr - head_ptr;
    assign alloc_rob_entry = tail_idx;

    // Full is judged from registered pointers, so a same-cycle retirement does not free a slot yet.
    assign alloc_fire  = alloc_valid && !rob_full && !flush;
    assign wb_ok       = valid_reg[wb_rob_entry] && !done_reg[wb_rob_entry];
    assign wb_fire     = wb_valid && !flush && wb_ok;
    assign wb_bad      = wb_valid && !flush && !wb_ok;
    assign commit_fire = !flush && valid_reg[head_idx] && done_reg[head_idx];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alloc_sel[gi]  = alloc_fire  && (tail_idx == ROB_ID_SIZE'(gi));
            assign wb_sel[gi]     = wb_fire     && (wb_rob_entry == ROB_ID_SIZE'(gi));
            assign commit_sel[gi] = commit_fire && (head_idx == ROB_ID_SIZE'(gi));
        end
    endgenerate

    rob_ptr #(.ID_SIZE(ROB_ID_SIZE)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .inc   (commit_fire),
        .ptr   (head_ptr)
    );

    rob_ptr #(.ID_SIZE(ROB_ID_SIZE)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .inc   (alloc_fire),
        .ptr   (tail_ptr)
    );

    // Alloc only targets a free slot and commit only a valid one, so they never hit the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            done_reg  <= '0;
        end else if (flush) begin
            valid_reg <= '0;
            done_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) begin
                    valid_reg[i] <= 1'b1;
                    done_reg[i]  <= 1'b0;
                end else begin
                    if (commit_sel[i]) valid_reg[i] <= 1'b0;
                    if (wb_sel[i])     done_reg[i]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_sel[i]) begin
                dest_mem[i]  <= alloc_dest_reg;
                store_reg[i] <= alloc_is_store;
            end
            if (wb_sel[i]) begin
                data_mem[i] <= wb_data;
                ctrl_mem[i] <= wb_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_valid     <= 1'b0;
            commit_store     <= 1'b0;
            commit_rob_entry <= '0;
            commit_dest_reg  <= '0;
            commit_data      <= '0;
            commit_ctrl      <= '0;
            wb_err           <= 1'b0;
        end else if (flush) begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            wb_err       <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            commit_store <= commit_fire && store_reg[head_idx];
            if (commit_fire) begin
                commit_rob_entry <= head_idx;
                commit_dest_reg  <= dest_mem[head_idx];
                commit_data      <= data_mem[head_idx];
                commit_ctrl      <= ctrl_mem[head_idx];
            end
            if (wb_bad) wb_err <= 1'b1;
        end
    end

endmodule
